// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader and instruction RAM holding the CPU in reset until loaded
// Optional trailer checksum state is enabled by defining IMEM_CHECKSUM_EN.
module imem_loader #(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_start,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid,
    output logic                byte_ready,
    input  logic [ADDRSIZE-1:0] INS_ADDR,
    output logic [0:WIDTH-1]    INS_MEM,
    output logic                cpu_rst,
    output logic                load_busy,
    output logic                load_err,
    output logic [ADDRSIZE:0]   words_loaded
);
    localparam int BYTES = WIDTH / 8;
    localparam int DEPTH = 1 << ADDRSIZE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
`ifdef IMEM_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_RUN,
        S_ERR
    } state_t;

    state_t                state_q, state_d, after_data;
    logic [15:0]           cnt_q, cnt_d;
    logic [ADDRSIZE-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDRSIZE:0]     words_q, words_d;
    logic [7:0]            idx_q, idx_d;
    logic [0:WIDTH-1]      word_q, word_d;
    logic                  wr_en;
    logic                  xfer;
`ifdef IMEM_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic [0:WIDTH-1] ram [0:DEPTH-1];

    assign xfer = byte_valid && byte_ready;

`ifdef IMEM_CHECKSUM_EN
    assign after_data = S_CHK;
`else
    assign after_data = S_DONE;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_addr_d = wr_addr_q;
        words_d   = words_q;
        idx_d     = idx_q;
        word_d    = word_q;
        wr_en     = 1'b0;
`ifdef IMEM_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                if (load_start) begin
                    state_d   = S_HDR;
                    cnt_d     = '0;
                    wr_addr_d = '0;
                    words_d   = '0;
                    idx_d     = '0;
                    word_d    = '0;
`ifdef IMEM_CHECKSUM_EN
                    csum_d    = '0;
`endif
                end
            end
            S_HDR: begin
                if (xfer) begin
                    cnt_d = {cnt_q[7:0], byte_in};
                    if (idx_q == 8'd0) begin
                        idx_d = 8'd1;
                    end else begin
                        idx_d = '0;
                        if (cnt_d == 16'd0)
                            state_d = after_data;
                        else if (17'(cnt_d) > 17'(DEPTH))
                            state_d = S_ERR;
                        else
                            state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    // first byte of a word ends up in INS_MEM[0:7]
                    word_d = {word_q[8:WIDTH-1], byte_in};
`ifdef IMEM_CHECKSUM_EN
                    csum_d = csum_q ^ byte_in;
`endif
                    if (idx_q == 8'(BYTES - 1)) begin
                        idx_d     = '0;
                        wr_en     = 1'b1;
                        wr_addr_d = wr_addr_q + 1'b1;
                        words_d   = words_q + 1'b1;
                        if (17'(words_d) == 17'(cnt_q))
                            state_d = after_data;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
`ifdef IMEM_CHECKSUM_EN
            S_CHK: begin
                if (xfer)
                    state_d = (byte_in == csum_q) ? S_DONE : S_ERR;
            end
`endif
            S_DONE:  state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wr_addr_q <= '0;
            words_q   <= '0;
            idx_q     <= '0;
            word_q    <= '0;
`ifdef IMEM_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_addr_q <= wr_addr_d;
            words_q   <= words_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
`ifdef IMEM_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    // RAM contents survive reset so an aborted load keeps its completed words
    always_ff @(posedge clk) begin
        if (wr_en)
            ram[wr_addr_q] <= word_d;
    end

`ifdef IMEM_CHECKSUM_EN
    assign byte_ready = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
`else
    assign byte_ready = (state_q == S_HDR) || (state_q == S_DATA);
`endif
    assign cpu_rst      = (state_q != S_RUN);
    assign load_busy    = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_DONE);
    assign load_err     = (state_q == S_ERR);
    assign words_loaded = words_q;
    assign INS_MEM      = (state_q == S_RUN) ? ram[INS_ADDR] : '0;

endmodule
